// File: rtl/fib_req_scheduler_if.sv
// fib_req_scheduler_if
//   Request/response bundle for the shared Fibonacci scheduler.
//   req0_* / req1_* : valid/ready request channels carrying term index n
//   rsp_*           : valid/ready response channel (id, value, overflow)
//   master : requester/consumer side      slave : scheduler side
interface fib_req_scheduler_if #(
  parameter int WIDTH = 32,
  parameter int NW    = 6
);
  logic             req0_valid;
  logic [NW-1:0]    req0_n;
  logic             req0_ready;
  logic             req1_valid;
  logic [NW-1:0]    req1_n;
  logic             req1_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_value;
  logic             rsp_ovf;

  modport master (
    output req0_valid, req0_n, req1_valid, req1_n, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_value, rsp_ovf
  );

  modport slave (
    input  req0_valid, req0_n, req1_valid, req1_n, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_value, rsp_ovf
  );
endinterface

// File: rtl/fib_req_scheduler.sv
// fib_req_scheduler
//   Two requesters share one iterative Fibonacci datapath. Requests are
//   arbitrated round-robin, F(n) is computed one add step per cycle and the
//   result is returned with requester id and an overflow flag.
//   clk  : clock, all state on posedge
//   rst  : synchronous active-high reset
//   bus  : request/response bundle (slave side)
//   busy : high whenever the FSM is not idle
module fib_req_scheduler #(
  parameter int WIDTH = 32,
  parameter int NW    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  fib_req_scheduler_if.slave   bus,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;

  state_t           r_state;
  state_t           w_next;

  logic             r_prio;     // 0: favour requester 0, 1: favour requester 1
  logic             r_id;
  logic [NW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_ovf_a;
  logic             r_ovf_b;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_value;
  logic             r_rsp_ovf;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;

  always_comb begin
    w_grant0 = bus.req0_valid & (~bus.req1_valid | ~r_prio);
    w_grant1 = bus.req1_valid & (~bus.req0_valid |  r_prio);
    w_accept = (r_state == S_IDLE) & (w_grant0 | w_grant1);
    {w_carry, w_sum} = {1'b0, r_a} + {1'b0, r_b};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept)             w_next = S_RUN;
      S_RUN:   if (r_cnt == '0)          w_next = S_RESP;
      S_RESP:  if (bus.rsp_ready)        w_next = S_IDLE;
      default:                           w_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.req0_ready = (r_state == S_IDLE) & w_grant0;
    bus.req1_ready = (r_state == S_IDLE) & w_grant1;
    bus.rsp_valid  = r_rsp_valid;
    bus.rsp_id     = r_rsp_id;
    bus.rsp_value  = r_rsp_value;
    bus.rsp_ovf    = r_rsp_ovf;
    busy           = (r_state != S_IDLE);
  end

  // Datapath. ovf_a/ovf_b track whether the true value held in a/b has
  // exceeded WIDTH bits, so a wrap in b only reaches rsp_ovf once b moves to a.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio      <= 1'b0;
      r_id        <= 1'b0;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_ovf_a     <= 1'b0;
      r_ovf_b     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_value <= '0;
      r_rsp_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_id    <= w_grant1;
            r_cnt   <= w_grant1 ? bus.req1_n : bus.req0_n;
            r_a     <= '0;
            r_b     <= WIDTH'(1);
            r_ovf_a <= 1'b0;
            r_ovf_b <= 1'b0;
          end
        end
        S_RUN: begin
          if (r_cnt != '0) begin
            r_a     <= r_b;
            r_b     <= w_sum;
            r_cnt   <= r_cnt - NW'(1);
            r_ovf_a <= r_ovf_b;
            r_ovf_b <= r_ovf_b | r_ovf_a | w_carry;
          end else begin
            r_rsp_value <= r_a;
            r_rsp_ovf   <= r_ovf_a;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_prio      <= ~r_rsp_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_req_scheduler.sv
module tb_fib_req_scheduler;

  localparam int WIDTH = 32;
  localparam int NW    = 6;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  fib_req_scheduler_if #(.WIDTH(WIDTH), .NW(NW)) bus ();

  fib_req_scheduler #(.WIDTH(WIDTH), .NW(NW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             id;
    int unsigned      n;
    logic [WIDTH-1:0] val;
    logic             ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Present a lone request at the negedge, confirm the grant, and return
  // #1 after the accepting edge with the request withdrawn.
  task automatic issue(input string tag, input logic id, input int unsigned n);
    @(negedge clk);
    if (id) begin bus.req1_valid = 1'b1; bus.req1_n = NW'(n); end
    else    begin bus.req0_valid = 1'b1; bus.req0_n = NW'(n); end
    #1;
    chk({tag, "_ready"}, {62'd0, bus.req1_ready, bus.req0_ready}, id ? 64'd2 : 64'd1);
    @(posedge clk); #1;
    if (id) bus.req1_valid = 1'b0;
    else    bus.req0_valid = 1'b0;
  endtask

  // Called #1 after the accepting edge: measure latency, check the
  // response, take it, and confirm return to idle.
  task automatic wait_rsp(input string tag, input int unsigned exp_lat, input logic exp_id,
                          input logic [WIDTH-1:0] exp_val, input logic exp_ovf);
    int unsigned edges = 0;
    while (!bus.rsp_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, "_lat"},   64'(edges), 64'(exp_lat));
    chk({tag, "_value"}, 64'(bus.rsp_value), 64'(exp_val));
    chk({tag, "_id"},    64'(bus.rsp_id), 64'(exp_id));
    chk({tag, "_ovf"},   64'(bus.rsp_ovf), 64'(exp_ovf));
    chk({tag, "_busy"},  64'(busy), 64'd1);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk({tag, "_drop"},  64'(bus.rsp_valid), 64'd0);
    chk({tag, "_idle"},  64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 0,  32'd0,          1'b0};
    vecs[1] = '{1'b1, 10, 32'd55,         1'b0};
    vecs[2] = '{1'b0, 47, 32'd2971215073, 1'b0};
    vecs[3] = '{1'b1, 48, 32'd512559680,  1'b1};
    vecs[4] = '{1'b0, 1,  32'd1,          1'b0};
    vecs[5] = '{1'b1, 2,  32'd1,          1'b0};
    vecs[6] = '{1'b0, 46, 32'd1836311903, 1'b0};
    vecs[7] = '{1'b1, 63, 32'd3350226146, 1'b1};

    rst            = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_n     = '0;
    bus.req1_n     = '0;
    bus.rsp_ready  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
    chk("rst_rsp_value", 64'(bus.rsp_value), 64'd0);
    chk("rst_rsp_ovf",   64'(bus.rsp_ovf),   64'd0);
    chk("rst_busy",      64'(busy),          64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_no_ready", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);

    // Single-requester table
    for (int i = 0; i < 8; i++) begin
      issue($sformatf("vec%0d", i), vecs[i].id, vecs[i].n);
      wait_rsp($sformatf("vec%0d", i), vecs[i].n + 1, vecs[i].id, vecs[i].val, vecs[i].ovf);
    end

    // Contention: both requesters valid continuously, grants alternate
    do_reset();
    bus.req0_n = 6'd3;
    bus.req1_n = 6'd3;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] eg;
      eg = (i % 2 == 1) ? 2'b10 : 2'b01;
      #1;
      chk($sformatf("rr%0d_grant", i), {62'd0, bus.req1_ready, bus.req0_ready}, 64'(eg));
      @(posedge clk); #1;
      wait_rsp($sformatf("rr%0d", i), 4, logic'(i % 2), 32'd2, 1'b0);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Backpressure: response held 20 cycles while requester 1 waits
    do_reset();
    issue("bp", 1'b0, 5);
    bus.req1_n     = 6'd1;
    bus.req1_valid = 1'b1;
    begin
      int unsigned edges = 0;
      while (!bus.rsp_valid && edges < 200) begin
        @(posedge clk); #1;
        edges++;
      end
      chk("bp_lat", 64'(edges), 64'd6);
    end
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("bp_hold%0d", i),
          {26'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_value, bus.rsp_ovf,
           bus.req0_ready, bus.req1_ready, busy},
          {26'd0, 1'b1, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1});
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("bp_taken",      64'(bus.rsp_valid),  64'd0);
    chk("bp_idle",       64'(busy),           64'd0);
    chk("bp_next_ready", 64'(bus.req1_ready), 64'd1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    chk("bp_next_busy",  64'(busy),           64'd1);
    wait_rsp("bp_next", 2, 1'b1, 32'd1, 1'b0);

    // Reset mid-run: leave pointer favouring requester 1 first
    issue("pre", 1'b0, 2);
    wait_rsp("pre", 3, 1'b0, 32'd1, 1'b0);
    issue("mid", 1'b1, 30);
    bus.req0_n     = 6'd4;
    bus.req0_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_run_no_ready", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
    chk("mid_run_busy",     64'(busy), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    bus.req1_n     = 6'd4;
    bus.req1_valid = 1'b1;
    @(posedge clk); #1;
    chk("mrst_busy",      64'(busy),          64'd0);
    chk("mrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mrst_ptr",       {62'd0, bus.req1_ready, bus.req0_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_rsp("mrst_after", 5, 1'b0, 32'd3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
